// File: rtl/ram_io_responder_if.sv
// Byte-serial memory bus between the initiator (memory_controller) and the RAM/IO responder.
interface ram_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (output mem_a, output mem_dout, output mem_wr,
                  input  mem_din, input io_buffer_full);
  modport slave  (input  mem_a, input mem_dout, input mem_wr,
                  output mem_din, output io_buffer_full);
endinterface

// File: rtl/ram_io_responder.sv
// Responder for the byte-serial bus: unified RAM, UART data/status window, TX FIFO and halt flag.
// One byte per cycle, fixed 1-cycle read latency, no stalls.
module ram_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int IO_FIFO_AW  = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_io_responder_if.slave    bus,
  output logic [7:0]           uart_tx_data_o,
  output logic                 uart_tx_valid_o,
  input  logic                 uart_tx_ready_i,
  input  logic [7:0]           uart_rx_data_i,
  input  logic                 uart_rx_valid_i,
  output logic                 uart_rx_pop_o,
  output logic                 sim_halt_o,
  output logic                 io_overflow_o
);
  localparam int DEPTH = 1 << IO_FIFO_AW;
  localparam int PW    = IO_FIFO_AW + 1;

  logic io_sel, uart_sel, stat_sel, ram_we, rx_rd, same_rd;
  logic push_req, push_ok, pop, fifo_full;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [ADDR_WIDTH-1:0] ram_idx;

  logic [7:0]  ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0]  ram_rd_q;
  logic [7:0]  fifo_mem [0:DEPTH-1];

  logic        sel_ram_q, sel_ram_d;
  logic [7:0]  io_rd_q, io_rd_d;
  logic        rx_pop_q, rx_pop_d;
  logic        prev_rx_rd_q;
  logic [31:0] prev_a_q;
  logic        halt_q, overflow_q, buf_full_q, buf_full_d;

  assign io_sel   = (bus.mem_a[17:16] == 2'b11);
  assign uart_sel = io_sel && (bus.mem_a[2:0] == 3'd0);
  assign stat_sel = io_sel && (bus.mem_a[2:0] == 3'd4);
  assign ram_we   = bus.mem_wr && !io_sel;
  assign ram_idx  = bus.mem_a[ADDR_WIDTH-1:0];

  // Sync-read RAM; a write followed next cycle by a read of the same byte sees the new value.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_idx] <= bus.mem_dout;
    ram_rd_q <= ram[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_q[IO_FIFO_AW-1:0]] <= bus.mem_dout;
  end

  assign count_q         = wr_ptr_q - rd_ptr_q;
  assign uart_tx_valid_o = (count_q != '0);
  assign uart_tx_data_o  = uart_tx_valid_o ? fifo_mem[rd_ptr_q[IO_FIFO_AW-1:0]] : 8'h00;
  assign fifo_full       = (count_q == PW'(DEPTH));
  assign pop             = uart_tx_valid_o && uart_tx_ready_i;
  assign push_req        = uart_sel && bus.mem_wr;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign push_ok         = push_req && (!fifo_full || pop);
  assign wr_ptr_d        = wr_ptr_q + PW'(push_ok);
  assign rd_ptr_d        = rd_ptr_q + PW'(pop);
  assign count_d         = wr_ptr_d - rd_ptr_d;
  assign buf_full_d      = (DEPTH - int'(count_d)) <= FULL_MARGIN;

  // A UART read held on the same address consumes the rx byte only once.
  assign rx_rd   = uart_sel && !bus.mem_wr;
  assign same_rd = prev_rx_rd_q && (prev_a_q == bus.mem_a);

  always_comb begin
    sel_ram_d = 1'b0;
    io_rd_d   = 8'h00;
    rx_pop_d  = 1'b0;
    if (!bus.mem_wr) begin
      if (!io_sel) begin
        sel_ram_d = 1'b1;
      end else if (uart_sel) begin
        io_rd_d  = uart_rx_valid_i ? uart_rx_data_i : 8'h00;
        rx_pop_d = uart_rx_valid_i && !same_rd;
      end else if (stat_sel) begin
        io_rd_d = {6'b0, !uart_tx_valid_o, uart_rx_valid_i};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sel_ram_q    <= 1'b0;
      io_rd_q      <= 8'h00;
      rx_pop_q     <= 1'b0;
      prev_rx_rd_q <= 1'b0;
      prev_a_q     <= '0;
      halt_q       <= 1'b0;
      overflow_q   <= 1'b0;
      buf_full_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sel_ram_q    <= sel_ram_d;
      io_rd_q      <= io_rd_d;
      rx_pop_q     <= rx_pop_d;
      prev_rx_rd_q <= rx_rd;
      prev_a_q     <= bus.mem_a;
      buf_full_q   <= buf_full_d;
      if (stat_sel && bus.mem_wr)
        halt_q <= 1'b1;
      if (push_req && !push_ok)
        overflow_q <= 1'b1;
    end
  end

  assign bus.mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
  assign bus.io_buffer_full = buf_full_q;
  assign uart_rx_pop_o      = rx_pop_q;
  assign sim_halt_o         = halt_q;
  assign io_overflow_o      = overflow_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// Randomized + directed bench for ram_io_responder against a queue/array-based reference model.
module tb_ram_io_responder;
  logic clk, rst_n;
  logic [7:0] uart_tx_data, uart_rx_data;
  logic uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_pop, sim_halt, io_overflow;

  ram_io_responder_if bus ();

  ram_io_responder dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .uart_tx_data_o(uart_tx_data), .uart_tx_valid_o(uart_tx_valid),
    .uart_tx_ready_i(uart_tx_ready), .uart_rx_data_i(uart_rx_data),
    .uart_rx_valid_i(uart_rx_valid), .uart_rx_pop_o(uart_rx_pop),
    .sim_halt_o(sim_halt), .io_overflow_o(io_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit chk_en = 0;

  // reference model state
  logic [7:0]  mram [int];
  logic [7:0]  txq [$];
  logic [7:0]  exp_din;
  bit          din_known, m_halt, m_ovf, m_full, m_pop, prev_rd;
  logic [31:0] prev_a;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask

  task automatic model_reset();
    txq.delete();
    exp_din = 8'h00; din_known = 0;
    m_halt = 0; m_ovf = 0; m_full = 0; m_pop = 0; prev_rd = 0; prev_a = '0;
  endtask

  task automatic model_step();
    logic [31:0] a;
    bit io, popped, ok;
    int idx;
    a = bus.mem_a;
    idx = int'(a[16:0]);
    io = (a[17:16] == 2'b11);
    exp_din = 8'h00; din_known = 1; m_pop = 0; ok = 0;
    popped = (txq.size() > 0) && uart_tx_ready;
    if (bus.mem_wr) begin
      if (!io) mram[idx] = bus.mem_dout;
      else if (a[2:0] == 3'd0) begin
        ok = (txq.size() < 8) || popped;
        if (!ok) m_ovf = 1;
      end else if (a[2:0] == 3'd4) m_halt = 1;
    end else begin
      if (!io) begin
        if (mram.exists(idx)) exp_din = mram[idx];
        else din_known = 0;
      end else if (a[2:0] == 3'd0) begin
        exp_din = uart_rx_valid ? uart_rx_data : 8'h00;
        m_pop = uart_rx_valid && !(prev_rd && prev_a == a);
      end else if (a[2:0] == 3'd4) begin
        exp_din = {6'b0, txq.size() == 0, uart_rx_valid};
      end
    end
    prev_rd = !bus.mem_wr && io && (a[2:0] == 3'd0);
    prev_a = a;
    if (popped) void'(txq.pop_front());
    if (ok) txq.push_back(bus.mem_dout);
    m_full = (8 - txq.size()) <= 2;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (din_known) check("mem_din", bus.mem_din, exp_din);
      check("io_buffer_full", bus.io_buffer_full, m_full);
      check("uart_tx_valid", uart_tx_valid, txq.size() > 0);
      check("uart_tx_data", uart_tx_data, (txq.size() > 0) ? txq[0] : 8'h00);
      check("uart_rx_pop", uart_rx_pop, m_pop);
      check("sim_halt", sim_halt, m_halt);
      check("io_overflow", io_overflow, m_ovf);
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic w);
    bus.mem_a = a; bus.mem_dout = d; bus.mem_wr = w;
    @(posedge clk);
    model_step();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk_en = 1;
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_din"}, bus.mem_din, 8'h00);
    check({tag, "_full"}, bus.io_buffer_full, 1'b0);
    check({tag, "_txv"}, uart_tx_valid, 1'b0);
    check({tag, "_txd"}, uart_tx_data, 8'h00);
    check({tag, "_pop"}, uart_rx_pop, 1'b0);
    check({tag, "_halt"}, sim_halt, 1'b0);
    check({tag, "_ovf"}, io_overflow, 1'b0);
  endtask

  logic [7:0] pat [4];
  int pops;

  initial begin
    pat[0] = 8'h13; pat[1] = 8'h57; pat[2] = 8'h9B; pat[3] = 8'hDF;
    rst_n = 1'b0;
    bus.mem_a = '0; bus.mem_dout = '0; bus.mem_wr = 1'b0;
    uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_reset("por");
    rst_n = 1'b1;
    model_reset();
    chk_en = 1;

    // RAM write then back-to-back reads, plus write-then-read of the same byte
    for (int i = 0; i < 4; i++) cyc(32'h1000 + i, pat[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(32'h1000 + i, 8'h00, 1'b0);
      check("ram_rd_lit", bus.mem_din, pat[i]);
    end
    cyc(32'h2000, 8'hA5, 1'b1);
    check("wr_cycle_din", bus.mem_din, 8'h00);
    cyc(32'h2000, 8'h00, 1'b0);
    check("rd_after_wr", bus.mem_din, 8'hA5);

    // fill TX FIFO with the UART stalled, then overflow, then drain
    for (int i = 0; i < 8; i++) begin
      cyc(32'h30000, 8'h41 + 8'(i), 1'b1);
      check("full_after_push", bus.io_buffer_full, i >= 5);
    end
    check("ovf_before", io_overflow, 1'b0);
    cyc(32'h30000, 8'h49, 1'b1);
    check("ovf_after", io_overflow, 1'b1);
    uart_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", uart_tx_data, 8'h41 + 8'(i));
      cyc(32'h1000, 8'h00, 1'b0);
    end
    check("drain_empty", uart_tx_valid, 1'b0);

    // push and pop together at full
    do_reset();
    uart_tx_ready = 0;
    for (int i = 0; i < 8; i++) cyc(32'h30000, 8'h41 + 8'(i), 1'b1);
    uart_tx_ready = 1;
    cyc(32'h30000, 8'h50, 1'b1);
    check("pp_full_ovf", io_overflow, 1'b0);
    check("pp_full_bf", bus.io_buffer_full, 1'b1);
    check("pp_head", uart_tx_data, 8'h42);

    // held UART read pops once
    uart_rx_valid = 1; uart_rx_data = 8'h5A;
    pops = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(32'h30000, 8'h00, 1'b0);
      check("rx_din", bus.mem_din, 8'h5A);
      pops += int'(uart_rx_pop);
    end
    check("rx_pop_count", pops, 1);
    uart_rx_valid = 0;

    // drain, status read, halt
    for (int i = 0; i < 10; i++) cyc(32'h1001, 8'h00, 1'b0);
    cyc(32'h30004, 8'h00, 1'b0);
    check("status_lit", bus.mem_din, 8'h02);
    check("halt_before", sim_halt, 1'b0);
    cyc(32'h30004, 8'h77, 1'b1);
    check("halt_after", sim_halt, 1'b1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      logic w;
      int kind;
      uart_tx_ready = ($urandom_range(0, 3) != 0);
      uart_rx_valid = $urandom_range(0, 1);
      uart_rx_data  = 8'($urandom);
      kind = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      if (kind < 5)
        a = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 2)) << 16) | 32'($urandom_range(0, 63));
      else if (kind < 8)
        a = ($urandom & 32'hFFFC_0000) | 32'h30000 | 32'($urandom_range(0, 7));
      else begin
        a = bus.mem_a;
        w = 1'b0;
      end
      if (a[17:16] != 2'b11 && !w && !mram.exists(int'(a[16:0]))) w = 1'b1;
      cyc(a, 8'($urandom), w);
    end

    // async reset in the middle of a RAM read burst with bytes queued
    do_reset();
    uart_tx_ready = 0; uart_rx_valid = 0;
    for (int i = 0; i < 3; i++) cyc(32'h30000, 8'hC0 + 8'(i), 1'b1);
    check("pre_rst_txv", uart_tx_valid, 1'b1);
    cyc(32'h1000, 8'h00, 1'b0);
    cyc(32'h1001, 8'h00, 1'b0);
    chk_en = 0;
    bus.mem_a = 32'h1002;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs_reset("mid");
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk_en = 1;
    check("post_rst_txv", uart_tx_valid, 1'b0);
    cyc(32'h1000, 8'h00, 1'b0);
    check("post_rst_ram", bus.mem_din, 8'h13);
    cyc(32'h1003, 8'h00, 1'b0);
    check("post_rst_ram3", bus.mem_din, 8'hDF);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
